// File: rtl/ctrl_decode_if.sv
// ID-stage to ID/EX control-bank bus for the main-control decoder.
// master = IF/ID side driving the instruction; slave = the decoder.
interface ctrl_decode_if #(
  parameter int ALUOP_W    = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [31:0]           instr_i;
  logic                  instr_valid_i;
  logic                  flush_i;
  logic                  RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o;
  logic                  Jump_o, Link_o, MemRead_o, MemWrite_o, MemtoReg_o;
  logic [ALUOP_W-1:0]    ALU_op_o;
  logic [REG_ADDR_W-1:0] wr_reg_o;
  logic                  valid_o;
  logic                  stall_o;
  logic                  trap_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  modport master (
    output instr_i, instr_valid_i, flush_i,
    input  RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o, Jump_o, Link_o,
           MemRead_o, MemWrite_o, MemtoReg_o, ALU_op_o, wr_reg_o, valid_o,
           stall_o, trap_o, stall_cnt_o
  );
  modport slave (
    input  instr_i, instr_valid_i, flush_i,
    output RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o, Jump_o, Link_o,
           MemRead_o, MemWrite_o, MemtoReg_o, ALU_op_o, wr_reg_o, valid_o,
           stall_o, trap_o, stall_cnt_o
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Pipelined MIPS-subset main-control decoder: registers ID/EX controls,
// inserts one load-use bubble per hazard and traps on illegal opcodes.
module ctrl_decode_pipe #(
  parameter int ALUOP_W    = 4,
  parameter int REG_ADDR_W = 5,
  parameter bit EXT_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ctrl_decode_if.slave  bus
);
  localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_JAL = 6'd3, OP_BEQ = 6'd4,
                         OP_BNE = 6'd5, OP_ADDI = 6'd8, OP_SLTI = 6'd10,
                         OP_ORI = 6'd13, OP_LUI = 6'd15, OP_LW = 6'd35, OP_SW = 6'd43;

  typedef struct packed {
    logic                  reg_write, alu_src, reg_dst, branch, branch_ne;
    logic                  jump, link, mem_read, mem_write, mem_to_reg;
    logic [ALUOP_W-1:0]    alu_op;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic                  valid;
  } ctl_t;

  typedef enum logic {ST_RUN, ST_TRAP} state_t;

  function automatic ctl_t bubble_f();
    ctl_t c;
    c        = '0;
    c.alu_op = '1;
    return c;
  endfunction

  state_t                 state_q, state_d;
  ctl_t                   ctl_q, ctl_d, dec;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic                   illegal, reads_rs, reads_rt, hazard, stall;
  logic [5:0]             op;
  logic [REG_ADDR_W-1:0]  rs, rt, rd;
  logic                   unused_bits;

  assign op          = bus.instr_i[31:26];
  assign rs          = REG_ADDR_W'(bus.instr_i[25:21]);
  assign rt          = REG_ADDR_W'(bus.instr_i[20:16]);
  assign rd          = REG_ADDR_W'(bus.instr_i[15:11]);
  assign unused_bits = ^bus.instr_i[10:0];

  // Operand-read flags follow the raw opcode, so illegal encodings can still
  // stall behind a load before they trap.
  always_comb begin
    dec        = bubble_f();
    dec.valid  = 1'b1;
    dec.wr_reg = rt;
    illegal    = 1'b0;
    reads_rs   = 1'b1;
    reads_rt   = 1'b0;
    case (op)
      OP_R: begin
        reads_rt = 1'b1;
        dec.reg_write = 1'b1; dec.reg_dst = 1'b1;
        dec.alu_op = ALUOP_W'(2); dec.wr_reg = rd;
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALUOP_W'(0);
      end
      OP_BEQ: begin
        reads_rt = 1'b1;
        dec.branch = 1'b1; dec.alu_op = ALUOP_W'(1);
      end
      OP_BNE: begin
        reads_rt = 1'b1;
        illegal  = !EXT_EN;
        dec.branch = 1'b1; dec.branch_ne = 1'b1; dec.alu_op = ALUOP_W'(1);
      end
      OP_SLTI: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALUOP_W'(3);
      end
      OP_LW: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
        dec.mem_to_reg = 1'b1; dec.alu_op = ALUOP_W'(4);
      end
      OP_SW: begin
        reads_rt = 1'b1;
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = ALUOP_W'(5);
      end
      OP_ORI: begin
        illegal = !EXT_EN;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALUOP_W'(6);
      end
      OP_LUI: begin
        reads_rs = 1'b0;
        illegal  = !EXT_EN;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALUOP_W'(7);
      end
      OP_J: begin
        reads_rs = 1'b0;
        dec.jump = 1'b1;
      end
      OP_JAL: begin
        reads_rs = 1'b0;
        illegal  = !EXT_EN;
        dec.jump = 1'b1; dec.link = 1'b1; dec.reg_write = 1'b1;
        dec.wr_reg = REG_ADDR_W'(31);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign hazard = ctl_q.valid && ctl_q.mem_read && (ctl_q.wr_reg != '0) &&
                  bus.instr_valid_i &&
                  (((ctl_q.wr_reg == rs) && reads_rs) || ((ctl_q.wr_reg == rt) && reads_rt));

  always_comb begin
    state_d     = state_q;
    ctl_d       = bubble_f();
    stall_cnt_d = stall_cnt_q;
    stall       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.flush_i) begin
          ctl_d = bubble_f();
        end else if (hazard) begin
          stall       = 1'b1;
          stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end else if (illegal && bus.instr_valid_i) begin
          state_d = ST_TRAP;
        end else if (bus.instr_valid_i) begin
          ctl_d = dec;
        end
      end
      ST_TRAP: begin
        if (bus.flush_i) state_d = ST_RUN;
        else             stall   = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst_i) stall = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      ctl_q       <= bubble_f();
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.RegWrite_o  = ctl_q.reg_write;
  assign bus.ALUSrc_o    = ctl_q.alu_src;
  assign bus.RegDst_o    = ctl_q.reg_dst;
  assign bus.Branch_o    = ctl_q.branch;
  assign bus.BranchNe_o  = ctl_q.branch_ne;
  assign bus.Jump_o      = ctl_q.jump;
  assign bus.Link_o      = ctl_q.link;
  assign bus.MemRead_o   = ctl_q.mem_read;
  assign bus.MemWrite_o  = ctl_q.mem_write;
  assign bus.MemtoReg_o  = ctl_q.mem_to_reg;
  assign bus.ALU_op_o    = ctl_q.alu_op;
  assign bus.wr_reg_o    = ctl_q.wr_reg;
  assign bus.valid_o     = ctl_q.valid;
  assign bus.stall_o     = stall;
  assign bus.trap_o      = (state_q == ST_TRAP);
  assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (extended/16-bit counter and
// base/2-bit counter) share one stimulus and are compared against a model.
module tb_ctrl_decode_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        iv = 1'b0, fl = 1'b0;
  bit          chk_en = 1'b0;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ctrl_decode_if #(.ALUOP_W(4), .REG_ADDR_W(5), .CNT_W(16)) if0 ();
  ctrl_decode_if #(.ALUOP_W(4), .REG_ADDR_W(5), .CNT_W(2))  if1 ();

  assign if0.instr_i = instr; assign if0.instr_valid_i = iv; assign if0.flush_i = fl;
  assign if1.instr_i = instr; assign if1.instr_valid_i = iv; assign if1.flush_i = fl;

  ctrl_decode_pipe #(.ALUOP_W(4), .REG_ADDR_W(5), .EXT_EN(1'b1), .CNT_W(16))
    u0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  ctrl_decode_pipe #(.ALUOP_W(4), .REG_ADDR_W(5), .EXT_EN(1'b0), .CNT_W(2))
    u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

  // Control vector bit order: {RegWrite,ALUSrc,RegDst,Branch,BranchNe,Jump,Link,MemRead,MemWrite,MemtoReg}
  logic [9:0]  d_ctl [2];
  logic [3:0]  d_alu [2];
  logic [4:0]  d_wr  [2];
  logic        d_val [2], d_trap [2], d_stall [2];
  logic [31:0] d_cnt [2];

  assign d_ctl[0] = {if0.RegWrite_o, if0.ALUSrc_o, if0.RegDst_o, if0.Branch_o, if0.BranchNe_o,
                     if0.Jump_o, if0.Link_o, if0.MemRead_o, if0.MemWrite_o, if0.MemtoReg_o};
  assign d_ctl[1] = {if1.RegWrite_o, if1.ALUSrc_o, if1.RegDst_o, if1.Branch_o, if1.BranchNe_o,
                     if1.Jump_o, if1.Link_o, if1.MemRead_o, if1.MemWrite_o, if1.MemtoReg_o};
  assign d_alu[0] = if0.ALU_op_o;    assign d_alu[1] = if1.ALU_op_o;
  assign d_wr[0]  = if0.wr_reg_o;    assign d_wr[1]  = if1.wr_reg_o;
  assign d_val[0] = if0.valid_o;     assign d_val[1] = if1.valid_o;
  assign d_trap[0] = if0.trap_o;     assign d_trap[1] = if1.trap_o;
  assign d_stall[0] = if0.stall_o;   assign d_stall[1] = if1.stall_o;
  assign d_cnt[0] = 32'(if0.stall_cnt_o);
  assign d_cnt[1] = 32'(if1.stall_cnt_o);

  // ---------------- behavioural model ----------------
  logic [9:0] m_ctl [2];
  logic [3:0] m_alu [2];
  logic [4:0] m_wr  [2];
  logic       m_val [2], m_trap [2];
  int         m_cnt [2];
  int         cmax  [2] = '{65535, 3};

  // Opcode table: {controls, alu_op}; ok=0 for anything not decodable.
  function automatic logic [13:0] tbl(input logic [5:0] op, input bit ext, output bit ok);
    ok = 1'b1;
    case (op)
      6'd0:  return {10'b1010000000, 4'd2};
      6'd8:  return {10'b1100000000, 4'd0};
      6'd4:  return {10'b0001000000, 4'd1};
      6'd10: return {10'b1100000000, 4'd3};
      6'd35: return {10'b1100000101, 4'd4};
      6'd43: return {10'b0100000010, 4'd5};
      6'd2:  return {10'b0000010000, 4'hF};
      6'd5:  begin ok = ext; return {10'b0001100000, 4'd1}; end
      6'd13: begin ok = ext; return {10'b1100000000, 4'd6}; end
      6'd15: begin ok = ext; return {10'b1100000000, 4'd7}; end
      6'd3:  begin ok = ext; return {10'b1000011000, 4'hF}; end
      default: begin ok = 1'b0; return {10'd0, 4'hF}; end
    endcase
  endfunction

  function automatic bit m_haz(input int k);
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit rrs, rrt;
    op  = instr[31:26];
    rs  = instr[25:21];
    rt  = instr[20:16];
    rrs = !(op inside {6'd2, 6'd3, 6'd15});
    rrt = op inside {6'd0, 6'd4, 6'd5, 6'd43};
    return m_val[k] && m_ctl[k][2] && (m_wr[k] != 5'd0) && iv &&
           (((m_wr[k] == rs) && rrs) || ((m_wr[k] == rt) && rrt));
  endfunction

  function automatic bit m_stall(input int k);
    if (rst)       return 1'b0;
    if (m_trap[k]) return !fl;
    return !fl && m_haz(k);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit          h, ok;
      logic [13:0] e;
      logic [9:0]  n_ctl;
      logic [3:0]  n_alu;
      logic [4:0]  n_wr;
      logic        n_val;
      h = m_haz(k);
      e = tbl(instr[31:26], k == 0, ok);
      n_ctl = '0; n_alu = 4'hF; n_wr = '0; n_val = 1'b0;
      if (rst) begin
        m_trap[k] = 1'b0; m_cnt[k] = 0;
      end else if (m_trap[k]) begin
        if (fl) m_trap[k] = 1'b0;
      end else if (fl) begin
        n_val = 1'b0;
      end else if (h) begin
        if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
      end else if (iv && !ok) begin
        m_trap[k] = 1'b1;
      end else if (iv) begin
        n_ctl = e[13:4]; n_alu = e[3:0]; n_val = 1'b1;
        n_wr  = (instr[31:26] == 6'd0) ? instr[15:11] :
                (instr[31:26] == 6'd3) ? 5'd31 : instr[20:16];
      end
      m_ctl[k] = n_ctl; m_alu[k] = n_alu; m_wr[k] = n_wr; m_val[k] = n_val;
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("ctl",   k, 32'(d_ctl[k]),   32'(m_ctl[k]));
        chk("alu",   k, 32'(d_alu[k]),   32'(m_alu[k]));
        chk("wr",    k, 32'(d_wr[k]),    32'(m_wr[k]));
        chk("valid", k, 32'(d_val[k]),   32'(m_val[k]));
        chk("trap",  k, 32'(d_trap[k]),  32'(m_trap[k]));
        chk("cnt",   k, d_cnt[k],        32'(m_cnt[k]));
        chk("stall", k, 32'(d_stall[k]), 32'(m_stall(k)));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  task automatic cyc(input logic [31:0] i, input logic v, input logic f);
    @(posedge clk); #1;
    instr = i; iv = v; fl = f;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 0, 32'(d_val[0]), 0);
    chk("rst_alu",   0, 32'(d_alu[0]), 32'hF);
    chk("rst_trap",  0, 32'(d_trap[0]), 0);
    chk("rst_cnt",   0, d_cnt[0], 0);
    chk("rst_stall", 0, 32'(d_stall[0]), 0);
    rst = 1'b0; chk_en = 1'b1;

    // ADDI rt=5
    cyc(mk(8, 0, 5, 0), 1, 0);
    cyc(0, 0, 0); #1;
    chk("addi_regwrite", 0, 32'(d_ctl[0][9]), 1);
    chk("addi_alusrc",   0, 32'(d_ctl[0][8]), 1);
    chk("addi_alu",      0, 32'(d_alu[0]), 0);
    chk("addi_wr",       0, 32'(d_wr[0]), 5);
    chk("addi_valid",    0, 32'(d_val[0]), 1);

    // LW rt=8 then R rs=8: one bubble, then R issues
    cyc(mk(35, 1, 8, 0), 1, 0);
    cyc(mk(0, 8, 2, 3), 1, 0); #1;
    chk("lu_stall", 0, 32'(d_stall[0]), 1);
    cyc(mk(0, 8, 2, 3), 1, 0); #1;
    chk("lu_bubble_valid", 0, 32'(d_val[0]), 0);
    chk("lu_bubble_alu",   0, 32'(d_alu[0]), 32'hF);
    chk("lu_cnt",          0, d_cnt[0], 1);
    chk("lu_restall",      0, 32'(d_stall[0]), 0);
    cyc(0, 0, 0); #1;
    chk("r_regdst", 0, 32'(d_ctl[0][7]), 1);
    chk("r_alu",    0, 32'(d_alu[0]), 2);
    chk("r_wr",     0, 32'(d_wr[0]), 3);

    // LW to $0 never stalls; LUI does not read rs
    cyc(mk(35, 1, 0, 0), 1, 0);
    cyc(mk(43, 0, 4, 0), 1, 0); #1;
    chk("r0_nostall", 0, 32'(d_stall[0]), 0);
    cyc(mk(35, 1, 9, 0), 1, 0);
    cyc(mk(15, 9, 6, 0), 1, 0); #1;
    chk("lui_nostall", 0, 32'(d_stall[0]), 0);
    cyc(0, 0, 1); #1;
    chk("lui_alu", 0, 32'(d_alu[0]), 7);
    chk("lui_trap_base", 1, 32'(d_trap[1]), 1);

    // JAL: decoded on u0, traps u1
    cyc(mk(3, 0, 0, 0), 1, 0);
    cyc(0, 0, 0); #1;
    chk("jal_jump", 0, 32'(d_ctl[0][4]), 1);
    chk("jal_link", 0, 32'(d_ctl[0][3]), 1);
    chk("jal_rw",   0, 32'(d_ctl[0][9]), 1);
    chk("jal_wr",   0, 32'(d_wr[0]), 31);
    chk("jal_trap", 1, 32'(d_trap[1]), 1);
    cyc(0, 0, 0); cyc(0, 0, 0); #1;
    chk("trap_stall", 1, 32'(d_stall[1]), 1);
    cyc(0, 0, 1); #1;
    chk("trap_flush_stall", 1, 32'(d_stall[1]), 0);
    cyc(0, 0, 0); #1;
    chk("trap_exit",  1, 32'(d_trap[1]), 0);
    chk("trap_valid", 1, 32'(d_val[1]), 0);

    // flush beats hazard
    cyc(mk(35, 1, 7, 0), 1, 0);
    cyc(mk(0, 7, 1, 2), 1, 1); #1;
    chk("flush_haz_stall", 0, 32'(d_stall[0]), 0);
    cyc(0, 0, 0); #1;
    chk("flush_haz_valid", 0, 32'(d_val[0]), 0);
    chk("flush_haz_cnt",   0, d_cnt[0], 1);

    // hazard beats illegal; illegal traps after the stall
    cyc(mk(35, 1, 12, 0), 1, 0);
    cyc(mk(63, 12, 0, 0), 1, 0); #1;
    chk("haz_ill_stall", 0, 32'(d_stall[0]), 1);
    cyc(mk(63, 12, 0, 0), 1, 0); #1;
    chk("haz_ill_notrap", 0, 32'(d_trap[0]), 0);
    chk("haz_ill_cnt",    0, d_cnt[0], 2);
    cyc(0, 0, 0); #1;
    chk("haz_ill_trap", 0, 32'(d_trap[0]), 1);

    // reset while trapped
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_trap_exit", 0, 32'(d_trap[0]), 0);
    chk("rst_trap_cnt",  0, d_cnt[0], 0);
    rst = 1'b0;

    // 2-bit counter saturation
    for (int p = 0; p < 4; p++) begin
      cyc(mk(35, 1, 10, 0), 1, 0);
      cyc(mk(8, 10, 11, 0), 1, 0);
      cyc(mk(8, 10, 11, 0), 1, 0); #1;
      chk("sat_cnt", 1, d_cnt[1], (p < 3) ? 32'(p + 1) : 32'd3);
    end
    chk("cnt16", 0, d_cnt[0], 4);

    cyc(0, 0, 0); cyc(0, 0, 0);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Pipelined main-control decoder for the MIPS-subset CPU, sitting between the IF/ID register and the EX stage. It decodes the opcode of the instruction in ID and registers all control signals into the ID/EX control bank. It detects load-use hazards and inserts one bubble, and traps illegal opcodes until the pipeline is flushed. It extends the single-cycle decode with BNE/JAL/ORI/LUI, a parametrised ALU-op width, destination-register selection and stall accounting.

## Interface
- ALUOP_W, 4, width of ALU_op_o; must be ≥4; codes below are zero-extended.
- REG_ADDR_W, 5, register-address width.
- EXT_EN, 1, 1 = decode BNE/JAL/ORI/LUI; 0 = those opcodes are illegal.
- CNT_W, 16, width of stall counter.
- Reset is synchronous and active-high; a single clock is used.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- instr_i  in  32  instruction in ID; op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
- instr_valid_i  in  1  instr_i is a real instruction; 0 = decode as bubble.
- flush_i  in  1  branch/jump taken or trap recovery; kill the ID instruction.
- RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o, Jump_o, Link_o, MemRead_o, MemWrite_o, MemtoReg_o  out  1 each  registered ID/EX controls.
- ALU_op_o  out  ALUOP_W  registered ALU class.
- wr_reg_o  out  REG_ADDR_W  registered destination register.
- valid_o  out  1  ID/EX holds a real instruction.
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- trap_o  out  1  registered; block is in TRAP state.
- stall_cnt_o  out  CNT_W  count of load-use bubbles inserted.

## Operation
- Opcode map and ALU_op:
  - R=0 → 2.
  - ADDI=8 → 0.
  - BEQ=4 and BNE=5 → 1.
  - SLTI=10 → 3.
  - LW=35 → 4.
  - SW=43 → 5.
  - ORI=13 → 6.
  - LUI=15 → 7.
  - J=2, JAL=3 and bubble → all-ones (NOP).
- Per-opcode controls:
  - ALUSrc is set for ADDI/SLTI/ORI/LUI/LW/SW.
  - RegDst is set for R.
  - Branch is set for BEQ/BNE; BranchNe is set for BNE only.
  - Jump is set for J/JAL; Link is set for JAL.
  - MemRead and MemtoReg are set for LW; MemWrite is set for SW.
  - RegWrite is set for R/ADDI/SLTI/ORI/LUI/LW/JAL.
- wr_reg_o: rd for R; 31 for JAL; rt otherwise; 0 for bubble.
- Bubble: all 1-bit controls 0, ALU_op all-ones, wr_reg 0, valid_o 0.
- Illegal opcode: any opcode outside the map, plus BNE/JAL/ORI/LUI when EXT_EN=0.
- Load-use hazard, all conditions required:
  - ID/EX is valid, MemRead_o=1 and wr_reg_o≠0.
  - instr_valid_i=1.
  - Either wr_reg_o==rs and the ID op reads rs (all except J/JAL/LUI), or wr_reg_o==rt and the ID op reads rt (R/BEQ/BNE/SW).
- FSM states RUN and TRAP.
  - RUN, priority order:
    - flush_i: load bubble.
    - Hazard: load bubble, stall_o=1, stall_cnt+1 (saturating at all-ones).
    - Illegal with instr_valid_i: load bubble, go to TRAP.
    - Otherwise: load decoded controls.
  - TRAP: stall_o=1, bubble loaded every cycle, trap_o=1. flush_i returns to RUN and loads a bubble that cycle.
- Bubble after a hazard clears the hazard next cycle; at most one consecutive bubble per load.

## Timing
- Decode latency 1 cycle: instr_i sampled at edge N appears on the outputs after edge N.
- stall_o is combinational from instr_i/instr_valid_i/flush_i and ID/EX state in the same cycle. It is 0 when flush_i=1 in RUN and 0 while rst_i=1.
- Reset (rst_i high at edge):
  - Outputs: all 1-bit controls 0, ALU_op all-ones, wr_reg 0, valid_o 0, trap_o 0, stall_cnt 0.
  - State: RUN.
  - rst_i overrides flush, hazard and TRAP mid-operation.
- trap_o rises one edge after the illegal opcode is sampled. It falls one edge after flush_i is sampled in TRAP.
- Simultaneous hazard and illegal opcode: hazard wins; the illegal opcode is re-decoded after the stall.
- stall_cnt_o saturates: at 2^CNT_W−1 further hazards leave it unchanged.

## Test plan
- Reset, then ADDI rt=5 valid → next cycle RegWrite=1, ALUSrc=1, ALU_op=0, wr_reg=5, valid=1, stall_o never asserted.
- LW rt=8, then R-type with rs=8 → stall_o=1 during the second cycle; ID/EX bubble (valid=0, ALU_op=4'hF); stall_cnt=1; the R-type re-presented issues with RegDst=1, ALU_op=2.
- LW rt=0, then SW with rs=0 → no stall. LW rt=9, then LUI with rs=9 → no stall (LUI does not read rs).
- JAL valid, EXT_EN=1 → Jump=1, Link=1, RegWrite=1, wr_reg=31. Same with EXT_EN=0 → trap_o=1 next cycle, stall_o held 1 until flush_i, then trap_o=0 and bubble loaded.
- flush_i asserted together with a hazard → bubble loaded, stall_o=0, stall_cnt unchanged. rst_i asserted in TRAP → trap_o=0 and stall_cnt=0 next cycle.
- CNT_W=2, four back-to-back load-use pairs → stall_cnt_o reads 1, 2, 3, 3.
